// File: rtl/parity_seq_ctrl.sv
// rtl/parity_seq_ctrl.sv - serial even/odd parity generate/check sequencer
//
// Optional feature macro: PARITY_SEQ_ERR_CNT_EN
//   defined   : saturating parity-error counter on err_count, cleared by clr_count
//   undefined : err_count tied to 0, clr_count ignored
//
// A word is accepted in IDLE, folded one bit per clock through a 1-bit XOR
// accumulator in SHIFT (exactly DATA_W cycles), and the result is held in
// DONE until the consumer takes it. Mode bits are captured on accept only.

module parity_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_par,
    input  logic              cfg_odd,
    input  logic              cfg_check,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_par,
    output logic              out_err,
    output logic              busy,
    input  logic              clr_count,
    output logic [CNT_W-1:0]  err_count
);

    localparam int             BIT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  sreg;
    logic               acc;
    logic [BIT_W-1:0]   cnt;
    logic               par_l;
    logic               odd_l;
    logic               check_l;

    // Accumulator value including the bit folded on the final SHIFT edge,
    // so the result can be registered on the same edge that enters DONE.
    logic               acc_next;
    assign acc_next = acc ^ sreg[0];

    // Sequencer: accept, serial fold, then hold the registered result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sreg      <= '0;
            acc       <= 1'b0;
            cnt       <= '0;
            par_l     <= 1'b0;
            odd_l     <= 1'b0;
            check_l   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_par   <= 1'b0;
            out_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sreg     <= in_data;
                        par_l    <= in_par;
                        odd_l    <= cfg_odd;
                        check_l  <= cfg_check;
                        acc      <= 1'b0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc  <= acc_next;
                    sreg <= sreg >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        out_valid <= 1'b1;
                        out_par   <= acc_next ^ odd_l;
                        out_err   <= check_l & (acc_next ^ par_l ^ odd_l);
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // out_par/out_err are left untouched so they stay stable
                    // for the whole time out_valid is high.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef PARITY_SEQ_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q;
    logic             result_taken;

    assign result_taken = out_valid && out_ready;

    // Saturating error counter; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (clr_count) begin
            err_cnt_q <= '0;
        end else if (result_taken && out_err && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_count = err_cnt_q;
`else
    logic unused_clr_count;

    assign unused_clr_count = clr_count;
    assign err_count        = '0;
`endif

endmodule
